stack_ex_ctrl: RTL and testbench

//  EX-stage sequencer directly upstream of the 16x16 stack memory.
//  - Turns decoded PUSH/POP/CALL/RET ops into one-cycle Stack_In/Out enables.
//  - Captures popped data for writeback and generates CALL/RET PC redirects.
//  - Stalls the pipeline while a stack access is in flight.
//  - Flags overflow, underflow, illegal ops and flag/depth mismatches.

---
 rtl/stack_ctrl_pkg.sv | 16 +
 rtl/stack_ex_ctrl.sv | 137 +++++++++++++
 tb/tb_stack_ex_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared op codes and FSM encodings for the EX-stage stack sequencer.
package stack_ctrl_pkg;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_PUSH = 3'd1;
   localparam logic [2:0] OP_POP  = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PUSH_ISS = 2'd1,
      ST_POP_ISS  = 2'd2
   } state_t;

endpackage

// File: rtl/stack_ex_ctrl.sv
// EX-stage sequencer for the stack memory: issues push/pop strobes, captures
// pop data, generates CALL/RET redirects and tracks sticky error flags.
module stack_ex_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int PC_W   = 16,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   input  logic [2:0]        op_code,
   input  logic [DATA_W-1:0] op_data,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic              Empty,
   input  logic              Full,
   input  logic [DATA_W-1:0] Stack_Out_EX,
   output logic              Stack_In_Enable_EX,
   output logic              Stack_Out_Enable_EX,
   output logic [DATA_W-1:0] Stack_In_EX,
   output logic              stall,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic              pc_redirect,
   output logic [PC_W-1:0]   pc_target,
   input  logic              clr_err,
   output logic              overflow_err,
   output logic              underflow_err,
   output logic              illegal_err,
   output logic              sync_err
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_MAX = CNT_W'(DEPTH);

   state_t           state;
   logic             is_ret;
   logic [CNT_W-1:0] depth;
   logic [PC_W-1:0]  ret_pc;

   logic accept, is_push_op, is_pop_op;
   logic ovf_set, unf_set, ill_set, sync_set;

   // Return address wraps within PC_W before being widened onto the stack.
   assign ret_pc     = ex_pc + PC_W'(1);
   assign accept     = (state == ST_IDLE) && op_valid;
   assign is_push_op = (op_code == OP_PUSH) || (op_code == OP_CALL);
   assign is_pop_op  = (op_code == OP_POP)  || (op_code == OP_RET);
   assign ovf_set    = accept && is_push_op && Full;
   assign unf_set    = accept && is_pop_op && Empty;
   assign ill_set    = accept && (op_code > OP_RET);
   assign sync_set   = (state == ST_IDLE) &&
                       (((depth == '0) != Empty) || ((depth == DEPTH_MAX) != Full));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state               <= ST_IDLE;
         is_ret              <= 1'b0;
         Stack_In_Enable_EX  <= 1'b0;
         Stack_Out_Enable_EX <= 1'b0;
         Stack_In_EX         <= '0;
         stall               <= 1'b0;
         wb_valid            <= 1'b0;
         wb_data             <= '0;
         pc_redirect         <= 1'b0;
         pc_target           <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               wb_valid    <= 1'b0;
               pc_redirect <= 1'b0;
               if (op_valid) begin
                  if (is_push_op && !Full) begin
                     state              <= ST_PUSH_ISS;
                     Stack_In_Enable_EX <= 1'b1;
                     stall              <= 1'b1;
                     if (op_code == OP_CALL) begin
                        Stack_In_EX <= DATA_W'(ret_pc);
                        pc_redirect <= 1'b1;
                        pc_target   <= op_data[PC_W-1:0];
                     end else begin
                        Stack_In_EX <= op_data;
                     end
                  end else if (is_pop_op && !Empty) begin
                     state               <= ST_POP_ISS;
                     Stack_Out_Enable_EX <= 1'b1;
                     stall               <= 1'b1;
                     is_ret              <= (op_code == OP_RET);
                  end
               end
            end
            ST_PUSH_ISS: begin
               state              <= ST_IDLE;
               Stack_In_Enable_EX <= 1'b0;
               stall              <= 1'b0;
               pc_redirect        <= 1'b0;
            end
            ST_POP_ISS: begin
               // Memory updated its output at the negedge inside this cycle.
               state               <= ST_IDLE;
               Stack_Out_Enable_EX <= 1'b0;
               stall               <= 1'b0;
               if (is_ret) begin
                  pc_redirect <= 1'b1;
                  pc_target   <= Stack_Out_EX[PC_W-1:0];
               end else begin
                  wb_valid <= 1'b1;
                  wb_data  <= Stack_Out_EX;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         depth         <= '0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
         illegal_err   <= 1'b0;
         sync_err      <= 1'b0;
      end else begin
         if (state == ST_PUSH_ISS && depth != DEPTH_MAX)
            depth <= depth + CNT_W'(1);
         else if (state == ST_POP_ISS && depth != '0)
            depth <= depth - CNT_W'(1);
         // A new error in the clearing cycle keeps its flag set.
         overflow_err  <= ovf_set  | (overflow_err  & ~clr_err);
         underflow_err <= unf_set  | (underflow_err & ~clr_err);
         illegal_err   <= ill_set  | (illegal_err   & ~clr_err);
         sync_err      <= sync_set | (sync_err      & ~clr_err);
      end
   end

endmodule

// File: tb/tb_stack_ex_ctrl.sv
// Directed bench for stack_ex_ctrl with a behavioural 16x16 stack memory.
module tb_stack_ex_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic [2:0]  op_code = 3'd0;
   logic [15:0] op_data = 16'h0;
   logic [15:0] ex_pc = 16'h0;
   logic        Empty, Full;
   logic [15:0] Stack_Out_EX;
   logic        Stack_In_Enable_EX, Stack_Out_Enable_EX;
   logic [15:0] Stack_In_EX;
   logic        stall, wb_valid, pc_redirect;
   logic [15:0] wb_data, pc_target;
   logic        clr_err = 1'b0;
   logic        overflow_err, underflow_err, illegal_err, sync_err;

   int n_chk = 0;
   int n_fail = 0;

   // Stack memory model: acts on the negedge inside the strobe cycle.
   logic [15:0] mem [16];
   int          cnt;
   logic [15:0] out_q;
   logic        bad_empty = 1'b0;

   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= 0;
         out_q <= 16'h0;
      end else if (Stack_In_Enable_EX && cnt < 16) begin
         mem[cnt] <= Stack_In_EX;
         cnt      <= cnt + 1;
      end else if (Stack_Out_Enable_EX && cnt > 0) begin
         out_q <= mem[cnt-1];
         cnt   <= cnt - 1;
      end
   end

   assign Empty        = (cnt == 0) ^ bad_empty;
   assign Full         = (cnt == 16);
   assign Stack_Out_EX = out_q;

   stack_ex_ctrl dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .op_data(op_data), .ex_pc(ex_pc), .Empty(Empty), .Full(Full),
      .Stack_Out_EX(Stack_Out_EX), .Stack_In_Enable_EX(Stack_In_Enable_EX),
      .Stack_Out_Enable_EX(Stack_Out_Enable_EX), .Stack_In_EX(Stack_In_EX),
      .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
      .pc_redirect(pc_redirect), .pc_target(pc_target), .clr_err(clr_err),
      .overflow_err(overflow_err), .underflow_err(underflow_err),
      .illegal_err(illegal_err), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an op and advance to C1 (one tick after the accept edge).
   task automatic issue(input logic [2:0] code, input logic [15:0] data, input logic [15:0] pc);
      op_valid = 1'b1;
      op_code  = code;
      op_data  = data;
      ex_pc    = pc;
      tick();
   endtask

   task automatic idle_op();
      op_valid = 1'b0;
      op_code  = 3'd0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_in_en", Stack_In_Enable_EX, 0);
      chk("rst_out_en", Stack_Out_Enable_EX, 0);
      chk("rst_stall", stall, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_redirect", pc_redirect, 0);
      chk("rst_errs", {overflow_err, underflow_err, illegal_err, sync_err}, 0);
      @(negedge clk);
      reset = 1'b1;

      // 1: PUSH 0x1234
      issue(3'd1, 16'h1234, 16'h0);
      chk("t1_in_en_c1", Stack_In_Enable_EX, 1);
      chk("t1_in_data", Stack_In_EX, 16'h1234);
      chk("t1_stall_c1", stall, 1);
      chk("t1_out_en_c1", Stack_Out_Enable_EX, 0);
      idle_op();
      tick();
      chk("t1_in_en_c2", Stack_In_Enable_EX, 0);
      chk("t1_stall_c2", stall, 0);
      chk("t1_empty_c2", Empty, 0);
      tick();
      chk("t1_sync", sync_err, 0);

      // 2: POP
      issue(3'd2, 16'h0, 16'h0);
      chk("t2_out_en_c1", Stack_Out_Enable_EX, 1);
      chk("t2_stall_c1", stall, 1);
      chk("t2_wb_c1", wb_valid, 0);
      idle_op();
      tick();
      chk("t2_wb_valid", wb_valid, 1);
      chk("t2_wb_data", wb_data, 16'h1234);
      chk("t2_out_en_c2", Stack_Out_Enable_EX, 0);
      chk("t2_empty", Empty, 1);
      tick();
      chk("t2_wb_one_cycle", wb_valid, 0);
      chk("t2_sync", sync_err, 0);

      // 3: CALL then RET
      issue(3'd3, 16'h0100, 16'h0040);
      chk("t3_call_in_en", Stack_In_Enable_EX, 1);
      chk("t3_call_ret_addr", Stack_In_EX, 16'h0041);
      chk("t3_call_redirect", pc_redirect, 1);
      chk("t3_call_target", pc_target, 16'h0100);
      idle_op();
      tick();
      chk("t3_call_redirect_c2", pc_redirect, 0);
      issue(3'd4, 16'h0, 16'h0);
      chk("t3_ret_out_en", Stack_Out_Enable_EX, 1);
      chk("t3_ret_redirect_c1", pc_redirect, 0);
      idle_op();
      tick();
      chk("t3_ret_redirect", pc_redirect, 1);
      chk("t3_ret_target", pc_target, 16'h0041);
      chk("t3_ret_no_wb", wb_valid, 0);
      tick();
      chk("t3_ret_redirect_drop", pc_redirect, 0);

      // 3b: CALL at PC 0xFFFF wraps the return address to 0
      issue(3'd3, 16'h0200, 16'hFFFF);
      chk("t3b_wrap", Stack_In_EX, 16'h0000);
      idle_op();
      tick();
      issue(3'd4, 16'h0, 16'h0);
      idle_op();
      tick();
      chk("t3b_ret_target", pc_target, 16'h0000);
      tick();

      // 4: fill to 16, overflow, clear interplay, drain, underflow
      for (int i = 0; i < 16; i++) begin
         issue(3'd1, 16'hA000 + 16'(i), 16'h0);
         idle_op();
         tick();
      end
      chk("t4_full", Full, 1);
      chk("t4_sync_full", sync_err, 0);
      issue(3'd1, 16'hBEEF, 16'h0);
      chk("t4_ovf_no_en", Stack_In_Enable_EX, 0);
      chk("t4_ovf_no_stall", stall, 0);
      chk("t4_ovf_flag", overflow_err, 1);
      idle_op();
      tick();
      chk("t4_ovf_sticky", overflow_err, 1);
      clr_err = 1'b1;
      issue(3'd3, 16'h0300, 16'h0010);
      chk("t4_clr_vs_set", overflow_err, 1);
      chk("t4_clr_vs_set_no_en", Stack_In_Enable_EX, 0);
      idle_op();
      tick();
      chk("t4_clr", overflow_err, 0);
      clr_err = 1'b0;
      for (int i = 0; i < 16; i++) begin
         issue(3'd2, 16'h0, 16'h0);
         idle_op();
         tick();
         chk("t4_lifo", wb_data, 16'hA000 + 16'(15 - i));
      end
      chk("t4_empty", Empty, 1);
      issue(3'd2, 16'h0, 16'h0);
      chk("t4_unf_no_en", Stack_Out_Enable_EX, 0);
      chk("t4_unf_flag", underflow_err, 1);
      idle_op();
      tick();
      chk("t4_unf_no_wb", wb_valid, 0);
      clr_err = 1'b1;
      tick();
      chk("t4_clr_both", {overflow_err, underflow_err}, 0);
      clr_err = 1'b0;

      // 5: reset asserted during POP_ISS C1
      issue(3'd1, 16'h5555, 16'h0);
      idle_op();
      tick();
      issue(3'd2, 16'h0, 16'h0);
      chk("t5_out_en_c1", Stack_Out_Enable_EX, 1);
      idle_op();
      reset = 1'b0;
      #1;
      chk("t5_out_en_drop", Stack_Out_Enable_EX, 0);
      chk("t5_stall_drop", stall, 0);
      tick();
      chk("t5_no_wb", wb_valid, 0);
      @(negedge clk);
      reset = 1'b1;
      issue(3'd1, 16'h7777, 16'h0);
      chk("t5_push_en", Stack_In_Enable_EX, 1);
      chk("t5_push_data", Stack_In_EX, 16'h7777);
      idle_op();
      tick();
      chk("t5_push_done", Empty, 0);
      tick();
      chk("t5_sync", sync_err, 0);

      // 6: illegal op code
      issue(3'd6, 16'h0, 16'h0);
      chk("t6_illegal", illegal_err, 1);
      chk("t6_no_en", {Stack_In_Enable_EX, Stack_Out_Enable_EX}, 0);
      chk("t6_no_stall", stall, 0);
      idle_op();
      clr_err = 1'b1;
      tick();
      chk("t6_clr", illegal_err, 0);
      clr_err = 1'b0;

      // Depth/flag disagreement: one entry held, Empty forced high
      bad_empty = 1'b1;
      tick();
      chk("t7_sync_set", sync_err, 1);
      bad_empty = 1'b0;
      clr_err = 1'b1;
      tick();
      chk("t7_sync_clr", sync_err, 0);
      clr_err = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
